// File: rtl/exec_sequencer_pkg.sv
// Shared types and constants for the execute sequencer.
// Package exec_seq_pkg: FSM state encoding, the opcodes the sequencer
// may execute, and the decoder format codes it qualifies them with.
package exec_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_WB     = 3'd3,
        S_RESP   = 3'd4
    } exec_state_t;

    localparam logic [6:0] OP_REG  = 7'b0110011;
    localparam logic [6:0] OP_REGW = 7'b0111011;
    localparam logic [6:0] OP_IMM  = 7'b0010011;
    localparam logic [6:0] OP_IMMW = 7'b0011011;

    localparam logic [2:0] FMT_R = 3'b000;
    localparam logic [2:0] FMT_I = 3'b001;

    // Only register-register and register-immediate ALU ops are executable,
    // and only when the decoder format agrees with the opcode class.
    function automatic logic is_exec_legal(input logic [2:0] fmt, input logic [6:0] opcode);
        logic r_ok;
        logic i_ok;
        r_ok = (fmt == FMT_R) && ((opcode == OP_REG) || (opcode == OP_REGW));
        i_ok = (fmt == FMT_I) && ((opcode == OP_IMM) || (opcode == OP_IMMW));
        return r_ok || i_ok;
    endfunction

endpackage

// File: rtl/exec_sequencer_if.sv
// Instruction request and response channels of the execute sequencer.
// slave is the sequencer side, master is the side issuing instructions.
interface exec_sequencer_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic [4:0]      out_rd;
    logic            out_illegal;

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_result, out_rd, out_illegal
    );

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_result, out_rd, out_illegal
    );
endinterface

// File: rtl/exec_perf_counter.sv
// Retired / illegal instruction counters, stepped on each accepted response.
// Both counters wrap naturally at 2^CNT_W.
module exec_perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_out_valid,
    input  logic             i_out_ready,
    input  logic             i_illegal,
    output logic [CNT_W-1:0] o_retired_cnt,
    output logic [CNT_W-1:0] o_illegal_cnt
);
    logic w_resp_hs;
    logic [CNT_W-1:0] r_retired_cnt;
    logic [CNT_W-1:0] r_illegal_cnt;

    assign w_resp_hs = i_out_valid && i_out_ready;

    // Count each response exactly once, in the bucket its illegal flag selects.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_retired_cnt <= '0;
            r_illegal_cnt <= '0;
        end else if (w_resp_hs) begin
            if (i_illegal) r_illegal_cnt <= r_illegal_cnt + 1'b1;
            else           r_retired_cnt <= r_retired_cnt + 1'b1;
        end
    end

    assign o_retired_cnt = r_retired_cnt;
    assign o_illegal_cnt = r_illegal_cnt;
endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle sequencer for the RV64 integer execute datapath.
// IDLE -> DECODE -> EXEC -> WB (-> RESP while the response is stalled).
// Optional feature: define EXEC_PERF_CNT_EN to build the retired/illegal
// instruction counters; otherwise both counter outputs are tied to zero.
module exec_sequencer
    import exec_seq_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    exec_sequencer_if.slave   bus,
    output logic [31:0]       ir_instr,
    input  logic [2:0]        dec_format,
    input  logic [4:0]        dec_rd,
    input  logic [XLEN-1:0]   alu_result,
    output logic              rf_we,
    output logic [4:0]        rf_waddr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              busy,
    output logic [CNT_W-1:0]  retired_cnt,
    output logic [CNT_W-1:0]  illegal_cnt
);
    exec_state_t     r_state;
    logic [31:0]     r_ir;
    logic [XLEN-1:0] r_result;
    logic [4:0]      r_rd;
    logic            r_illegal;
    logic            r_in_ready;
    logic            r_out_valid;
    logic            r_rf_we;
    logic            r_busy;

    // Sequencer FSM; every control output is registered alongside the state
    // so it is a pure function of the current state.
    // NOTE: all state here uses non-blocking assignments so every flop samples
    // pre-edge values; a blocking '=' would leak new values into this same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_ir        <= '0;
            r_result    <= '0;
            r_rd        <= '0;
            r_illegal   <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_rf_we     <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            // NOTE: default-low here makes rf_we a single-cycle pulse; only the
            // EXEC->WB transition can raise it, so RESP never repeats the write.
            r_rf_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_ir       <= bus.in_instr;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    r_rd      <= dec_rd;
                    r_illegal <= !is_exec_legal(dec_format, r_ir[6:0]);
                    r_state   <= S_EXEC;
                end
                S_EXEC: begin
                    r_result    <= r_illegal ? '0 : alu_result;
                    r_rf_we     <= !r_illegal && (r_rd != 5'd0);
                    r_out_valid <= 1'b1;
                    r_state     <= S_WB;
                end
                S_WB, S_RESP: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end else begin
                        r_state <= S_RESP;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign ir_instr        = r_ir;
    assign bus.in_ready    = r_in_ready;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_result  = r_result;
    assign bus.out_rd      = r_rd;
    assign bus.out_illegal = r_illegal;
    assign rf_we           = r_rf_we;
    assign rf_waddr        = r_rd;
    assign rf_wdata        = r_result;
    assign busy            = r_busy;

`ifdef EXEC_PERF_CNT_EN
    exec_perf_counter #(.CNT_W(CNT_W)) u_perf (
        .clk           (clk),
        .rst           (rst),
        .i_out_valid   (r_out_valid),
        .i_out_ready   (bus.out_ready),
        .i_illegal     (r_illegal),
        .o_retired_cnt (retired_cnt),
        .o_illegal_cnt (illegal_cnt)
    );
`else
    assign retired_cnt = '0;
    assign illegal_cnt = '0;
`endif

endmodule
